// File: rtl/regmap_uart_pkg.sv
// Shared definitions for the register-mapped UART transmitter:
// register word offsets, STATUS/CTRL bit positions and the FSM encoding.
package regmap_uart_pkg;

  localparam int ADDR_W = 14;

  localparam logic [ADDR_W-1:0] OFF_TXDATA  = 14'h0;
  localparam logic [ADDR_W-1:0] OFF_STATUS  = 14'h1;
  localparam logic [ADDR_W-1:0] OFF_CTRL    = 14'h2;
  localparam logic [ADDR_W-1:0] OFF_BAUDDIV = 14'h3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam int CTRL_TX_EN = 0;
  localparam int CTRL_IE    = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/regmap_uart_fifo.sv
// Byte FIFO for the UART transmitter; head entry is visible combinationally.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module regmap_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/regmap_uart_tx.sv
// Register-mapped 8N1 UART transmitter: reg file, read path, FIFO and bit FSM.
//   state | meaning
//   IDLE  | line high, waiting for tx_en and a queued byte
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); may chain straight into the next START
module regmap_uart_tx
  import regmap_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        reg_wen,
  input  logic [13:0] reg_waddr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_ren,
  input  logic [13:0] reg_raddr,
  output logic [31:0] reg_rdata,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]  ctrl_q;
  logic [15:0] baud_q;
  logic        ovf_q;

  logic        wr_txdata, wr_status, wr_ctrl, wr_baud;
  logic        fifo_pop, fifo_full, fifo_empty, push_drop;
  logic [7:0]  fifo_head;
  logic [CW-1:0] fifo_count;
  logic [31:0] count_ext;
  logic [3:0]  cnt_disp;
  logic [31:0] rd_next;
  logic        busy;
  logic        unused_wdata;

  tx_state_e   state_q, state_d;
  logic [15:0] bit_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        tx_q, tx_d;
  logic        load_bit, load_shift, shift_en, bit_end;

  assign wr_txdata = reg_wen && (reg_waddr == OFF_TXDATA);
  assign wr_status = reg_wen && (reg_waddr == OFF_STATUS);
  assign wr_ctrl   = reg_wen && (reg_waddr == OFF_CTRL);
  assign wr_baud   = reg_wen && (reg_waddr == OFF_BAUDDIV);
  assign push_drop = wr_txdata && fifo_full && !fifo_pop;
  assign unused_wdata = ^reg_wdata[31:16];

  regmap_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .wdata (reg_wdata[7:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      baud_q <= DEFAULT_DIV;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= reg_wdata[1:0];
      if (wr_baud) baud_q <= reg_wdata[15:0];
      if (push_drop)                         ovf_q <= 1'b1;
      else if (wr_status && reg_wdata[ST_OVF]) ovf_q <= 1'b0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign tx_irq    = ctrl_q[CTRL_IE] && fifo_empty && !busy;
  assign count_ext = 32'(fifo_count);
  assign cnt_disp  = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  // CTRL and BAUDDIV forward a same-cycle write; STATUS shows pre-edge state.
  always_comb begin
    rd_next = '0;
    case (reg_raddr)
      OFF_STATUS: begin
        rd_next[ST_FULL]                 = fifo_full;
        rd_next[ST_EMPTY]                = fifo_empty;
        rd_next[ST_BUSY]                 = busy;
        rd_next[ST_OVF]                  = ovf_q;
        rd_next[ST_CNT_LSB+3:ST_CNT_LSB] = cnt_disp;
      end
      OFF_CTRL:    rd_next[1:0]  = wr_ctrl ? reg_wdata[1:0]  : ctrl_q;
      OFF_BAUDDIV: rd_next[15:0] = wr_baud ? reg_wdata[15:0] : baud_q;
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset)       reg_rdata <= '0;
    else if (reg_ren) reg_rdata <= rd_next;
  end

  assign bit_end = (bit_cnt_q == 16'd0);

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    load_bit   = 1'b0;
    load_shift = 1'b0;
    shift_en   = 1'b0;
    tx_d       = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (ctrl_q[CTRL_TX_EN] && !fifo_empty) begin
          fifo_pop   = 1'b1;
          load_shift = 1'b1;
          load_bit   = 1'b1;
          tx_d       = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          load_bit = 1'b1;
          tx_d     = shift_q[0];
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          load_bit = 1'b1;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_en = 1'b1;
            tx_d     = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (ctrl_q[CTRL_TX_EN] && !fifo_empty) begin
            fifo_pop   = 1'b1;
            load_shift = 1'b1;
            load_bit   = 1'b1;
            tx_d       = 1'b0;
            state_d    = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Counter reloads from the live BAUDDIV at every bit start.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      tx_q      <= 1'b1;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      tx_q <= tx_d;
      if (load_bit)              bit_cnt_q <= baud_q;
      else if (bit_cnt_q != 0)   bit_cnt_q <= bit_cnt_q - 1'b1;
      if (load_shift) begin
        shift_q   <= fifo_head;
        bit_idx_q <= '0;
      end else if (shift_en) begin
        shift_q   <= {1'b0, shift_q[7:1]};
        bit_idx_q <= bit_idx_q + 1'b1;
      end
    end
  end

  assign uart_tx = tx_q;

endmodule
